// File: rtl/motoro3_pwm_multi_dt.sv
// CH-channel complementary PWM with a shared period counter, shadowed settings,
// minimum-on-time carry-over and per-pair dead-time insertion.
module motoro3_pwm_multi_dt #(
    parameter int unsigned CH = 3,
    parameter int unsigned CW = 12,
    parameter int unsigned DW = 6
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             en,
    input  logic             sync,
    input  logic [CW-1:0]    periodLen,
    input  logic [CH*CW-1:0] dutyWant,
    input  logic [CW-1:0]    minPulse,
    input  logic [DW-1:0]    deadTime,
    output logic [CH-1:0]    pwmH,
    output logic [CH-1:0]    pwmL,
    output logic             periodEnd
);

    typedef enum logic [1:0] {StIdle, StHi, StLo, StDead} chState_e;

    localparam logic [CW-1:0] CntOne = CW'(1);
    localparam logic [DW-1:0] DtOne  = DW'(1);

    logic            act, start, actQ;
    logic [CW-1:0]   cntQ, cntD;
    logic [CW-1:0]   perSQ, perSD, minSQ, minSD;
    logic [DW-1:0]   dtSQ, dtSD, dtNow;
    logic            periodEndD;
    logic [CH-1:0]   raw;
    logic [CW-1:0]   dutyCh  [CH];
    logic [CW:0]     sumW    [CH];
    logic [CW-1:0]   dEffNew [CH];
    logic [CW-1:0]   accNew  [CH];
    logic [CW-1:0]   dEffQ   [CH];
    logic [CW-1:0]   dEffD   [CH];
    logic [CW-1:0]   accQ    [CH];
    logic [CW-1:0]   accD    [CH];
    logic [DW-1:0]   dtCntQ  [CH];
    logic [DW-1:0]   dtCntD  [CH];
    chState_e        stQ     [CH];
    chState_e        stD     [CH];

    assign act   = en & (periodLen != '0);
    assign start = act & (~actQ | sync | (cntQ == perSQ - CntOne));
    // A restart loads deadTime on this edge, so transitions taken now must already use it.
    assign dtNow = start ? deadTime : dtSQ;

    // Effective duty for the period about to start, using the settings being loaded.
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            dutyCh[i]  = dutyWant[i*CW +: CW];
            sumW[i]    = {1'b0, accQ[i]} + {1'b0, dutyCh[i]};
            dEffNew[i] = '0;
            accNew[i]  = '0;
            if (minPulse == '0) begin
                dEffNew[i] = (dutyCh[i] > periodLen) ? periodLen : dutyCh[i];
            end else if (sumW[i] < {1'b0, minPulse}) begin
                accNew[i] = sumW[i][CW-1:0];
            end else begin
                dEffNew[i] = (sumW[i] > {1'b0, periodLen}) ? periodLen : sumW[i][CW-1:0];
            end
        end
    end

    always_comb begin
        cntD       = cntQ;
        perSD      = perSQ;
        minSD      = minSQ;
        dtSD       = dtSQ;
        periodEndD = 1'b0;
        for (int i = 0; i < CH; i++) begin
            dEffD[i]  = dEffQ[i];
            accD[i]   = accQ[i];
            stD[i]    = stQ[i];
            dtCntD[i] = dtCntQ[i];
            raw[i]    = cntQ < dEffQ[i];
        end

        if (!act) begin
            cntD = '0;
            for (int i = 0; i < CH; i++) begin
                // Stale duties would otherwise steer the first decision after re-enable.
                dEffD[i] = '0;
                stD[i]   = StIdle;
                if (!en) begin
                    accD[i] = '0;
                end
            end
        end else begin
            if (start) begin
                cntD       = '0;
                perSD      = periodLen;
                minSD      = minPulse;
                dtSD       = deadTime;
                periodEndD = actQ;
                for (int i = 0; i < CH; i++) begin
                    dEffD[i] = dEffNew[i];
                    accD[i]  = accNew[i];
                end
            end else begin
                cntD = cntQ + CntOne;
            end

            for (int i = 0; i < CH; i++) begin
                unique case (stQ[i])
                    StIdle, StHi, StLo: begin
                        if ((stQ[i] == StIdle) || ((stQ[i] == StHi) != raw[i])) begin
                            if (dtNow == '0) begin
                                stD[i] = raw[i] ? StHi : StLo;
                            end else begin
                                stD[i]    = StDead;
                                dtCntD[i] = dtNow;
                            end
                        end
                    end
                    StDead: begin
                        if (dtCntQ[i] <= DtOne) begin
                            stD[i] = raw[i] ? StHi : StLo;
                        end else begin
                            dtCntD[i] = dtCntQ[i] - DtOne;
                        end
                    end
                endcase
            end
        end
    end

    always_comb begin
        for (int i = 0; i < CH; i++) begin
            pwmH[i] = (stQ[i] == StHi);
            pwmL[i] = (stQ[i] == StLo);
        end
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            actQ      <= 1'b0;
            cntQ      <= '0;
            perSQ     <= '0;
            minSQ     <= '0;
            dtSQ      <= '0;
            periodEnd <= 1'b0;
            for (int i = 0; i < CH; i++) begin
                dEffQ[i]  <= '0;
                accQ[i]   <= '0;
                dtCntQ[i] <= '0;
                stQ[i]    <= StIdle;
            end
        end else begin
            actQ      <= act;
            cntQ      <= cntD;
            perSQ     <= perSD;
            minSQ     <= minSD;
            dtSQ      <= dtSD;
            periodEnd <= periodEndD;
            for (int i = 0; i < CH; i++) begin
                dEffQ[i]  <= dEffD[i];
                accQ[i]   <= accD[i];
                dtCntQ[i] <= dtCntD[i];
                stQ[i]    <= stD[i];
            end
        end
    end

endmodule

// File: tb/tb_motoro3_pwm_multi_dt.sv
// Bench for motoro3_pwm_multi_dt: cycle-level reference model plus windowed duty counts.
module tb_motoro3_pwm_multi_dt;

    localparam int CH = 3;
    localparam int CW = 12;
    localparam int DW = 6;

    logic             clk = 1'b0;
    logic             nRst, en, sync;
    logic [CW-1:0]    periodLen, minPulse;
    logic [CH*CW-1:0] dutyWant;
    logic [DW-1:0]    deadTime;
    logic [CH-1:0]    pwmH, pwmL;
    logic             periodEnd;

    int checks = 0;
    int errors = 0;

    // Reference model state; mOut: 0 = both off, 1 = high side, 2 = low side.
    int mCnt, mPer, mMin, mDt;
    int mDeff[CH], mAcc[CH], mOut[CH], mDeadLeft[CH];
    bit mActive;
    logic [CH-1:0] expH, expL;
    logic expPE;

    int hiCnt[CH], loCnt[CH], peCnt, offCnt;

    always #50 clk = ~clk;

    motoro3_pwm_multi_dt #(.CH(CH), .CW(CW), .DW(DW)) dut (
        .clk(clk), .nRst(nRst), .en(en), .sync(sync), .periodLen(periodLen),
        .dutyWant(dutyWant), .minPulse(minPulse), .deadTime(deadTime),
        .pwmH(pwmH), .pwmL(pwmL), .periodEnd(periodEnd)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            if (errors <= 30) $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    task automatic setDuty(input int d0, input int d1, input int d2);
        dutyWant = {CW'(d2), CW'(d1), CW'(d0)};
    endtask

    // Advances the model by one clock using the inputs currently applied.
    task automatic modelStep();
        bit start;
        int dtNow, duty, s, want;
        if (!nRst) begin
            mCnt = 0; mPer = 0; mMin = 0; mDt = 0; mActive = 0; expPE = 0;
            for (int i = 0; i < CH; i++) begin
                mDeff[i] = 0; mAcc[i] = 0; mOut[i] = 0; mDeadLeft[i] = 0;
            end
        end else if (!(en && periodLen != 0)) begin
            mCnt = 0; mActive = 0; expPE = 0;
            for (int i = 0; i < CH; i++) begin
                mDeff[i] = 0; mOut[i] = 0; mDeadLeft[i] = 0;
                if (!en) mAcc[i] = 0;
            end
        end else begin
            start = !mActive || sync || (mCnt == mPer - 1);
            dtNow = start ? int'(deadTime) : mDt;
            for (int i = 0; i < CH; i++) begin
                want = (mCnt < mDeff[i]) ? 1 : 2;
                if (mDeadLeft[i] > 0) begin
                    mDeadLeft[i]--;
                    if (mDeadLeft[i] == 0) mOut[i] = want;
                end else if (mOut[i] != want) begin
                    if (dtNow == 0) mOut[i] = want;
                    else begin
                        mOut[i] = 0;
                        mDeadLeft[i] = dtNow;
                    end
                end
            end
            expPE = start && mActive;
            if (start) begin
                mCnt = 0; mPer = periodLen; mMin = minPulse; mDt = deadTime;
                for (int i = 0; i < CH; i++) begin
                    duty = int'(dutyWant[i*CW +: CW]);
                    s = mAcc[i] + duty;
                    if (mMin == 0) begin
                        mDeff[i] = (duty > mPer) ? mPer : duty; mAcc[i] = 0;
                    end else if (s < mMin) begin
                        mDeff[i] = 0; mAcc[i] = s;
                    end else begin
                        mDeff[i] = (s > mPer) ? mPer : s; mAcc[i] = 0;
                    end
                end
            end else begin
                mCnt++;
            end
            mActive = 1;
        end
        for (int i = 0; i < CH; i++) begin
            expH[i] = (mOut[i] == 1);
            expL[i] = (mOut[i] == 2);
        end
    endtask

    task automatic tick();
        modelStep();
        @(posedge clk);
        #1;
        checkVal("pwmH", 32'(pwmH), 32'(expH));
        checkVal("pwmL", 32'(pwmL), 32'(expL));
        checkVal("periodEnd", 32'(periodEnd), 32'(expPE));
        checkVal("overlap", 32'(pwmH & pwmL), 32'd0);
        for (int i = 0; i < CH; i++) begin
            hiCnt[i] += int'(pwmH[i]);
            loCnt[i] += int'(pwmL[i]);
        end
        peCnt += int'(periodEnd);
        offCnt += int'(!pwmH[0] && !pwmL[0]);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic clearStats();
        for (int i = 0; i < CH; i++) begin
            hiCnt[i] = 0; loCnt[i] = 0;
        end
        peCnt = 0; offCnt = 0;
    endtask

    initial begin
        nRst = 1'b0; en = 1'b0; sync = 1'b0; periodLen = '0; minPulse = '0; deadTime = '0;
        setDuty(0, 0, 0);
        clearStats();
        ticks(3);

        // Basic three-duty run, no dead time.
        nRst = 1'b1; en = 1'b1; periodLen = 100; setDuty(20, 50, 80);
        ticks(250);
        clearStats();
        ticks(100);
        checkVal("win_hi0", hiCnt[0], 20);
        checkVal("win_hi1", hiCnt[1], 50);
        checkVal("win_hi2", hiCnt[2], 80);
        checkVal("win_lo2", loCnt[2], 20);
        checkVal("win_pe", peCnt, 1);

        // Dead time of 5 on a 50% duty.
        deadTime = 5; setDuty(50, 50, 50);
        ticks(250);
        clearStats();
        ticks(100);
        checkVal("dt_hi", hiCnt[1], 45);
        checkVal("dt_lo", loCnt[1], 45);

        // Carry-over of sub-minimum duties.
        deadTime = 0; minPulse = 32; setDuty(10, 10, 10);
        ticks(200);
        clearStats();
        ticks(400);
        checkVal("carry_hi", hiCnt[0], 40);
        checkVal("carry_pe", peCnt, 4);

        // Duty above the period saturates at 100%.
        minPulse = 0; setDuty(150, 150, 150);
        ticks(250);
        clearStats();
        ticks(100);
        checkVal("sat_hi", hiCnt[0], 100);
        checkVal("sat_lo", loCnt[0], 0);

        // Mid-period sync with new settings, then a sync on the natural wrap.
        setDuty(20, 50, 80);
        ticks(200);
        while (mCnt != 37) tick();
        periodLen = 60; setDuty(10, 30, 59);
        sync = 1'b1; tick(); sync = 1'b0;
        checkVal("sync_cnt", mCnt, 0);
        ticks(150);
        while (mCnt != 59) tick();
        clearStats();
        sync = 1'b1; tick(); sync = 1'b0;
        ticks(59);
        checkVal("sync_wrap_pe", peCnt, 1);
        checkVal("sync_wrap_hi", hiCnt[1], 30);

        // One-cycle reset mid-period with dead time 10.
        deadTime = 10; periodLen = 100; setDuty(50, 50, 50);
        ticks(237);
        nRst = 1'b0; tick();
        checkVal("rst_out", 32'(pwmH | pwmL), 32'd0);
        nRst = 1'b1;
        clearStats();
        ticks(11);
        checkVal("rst_dead", offCnt, 10);

        // Randomized settings, syncs, enable drops and resets.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 49) == 0) begin
                periodLen = CW'($urandom_range(0, 80));
                setDuty($urandom_range(0, 100), $urandom_range(0, 100), $urandom_range(0, 100));
                minPulse = ($urandom_range(0, 1) == 0) ? '0 : CW'($urandom_range(0, 40));
                deadTime = DW'($urandom_range(0, 7));
            end
            sync = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 199) == 0) en = ~en;
            if (!en && $urandom_range(0, 7) == 0) en = 1'b1;
            nRst = ($urandom_range(0, 499) != 0);
            tick();
        end
        sync = 1'b0; nRst = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule
